// File: rtl/npc_pkg.sv
// Shared definitions for the fetch/decode front end: reset PC, fetch FSM
// encoding and the exception codes that decode also consumes.
package npc_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  localparam logic [4:0] EC_INST_MISALIGN = 5'd0;
  localparam logic [4:0] EC_INST_FAULT    = 5'd1;
  localparam logic [4:0] EC_ILLEGAL       = 5'd2;
  localparam logic [4:0] EC_BREAK         = 5'd3;
  localparam logic [4:0] EC_ECALL_M       = 5'd11;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_out_buf.sv
// Single-entry {pc, inst, fault} buffer between fetch and decode.
// With IFU_MISALIGN_CHK_EN defined it also carries a misaligned-target flag.
module ifu_out_buf
  import npc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  input  logic [31:0]      load_inst,
  input  logic             load_fault,
`ifdef IFU_MISALIGN_CHK_EN
  input  logic             load_misalign,
`endif
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_inst,
  output logic             out_fault
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic             out_misalign
`endif
);

  // Payload only moves on load, so it holds steady while decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_fault <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      out_misalign <= 1'b0;
`endif
    end else if (load) begin
      out_valid <= 1'b1;
      out_pc    <= load_pc;
      out_inst  <= load_inst;
      out_fault <= load_fault;
`ifdef IFU_MISALIGN_CHK_EN
      out_misalign <= load_misalign;
`endif
    end else if (flush || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, one-outstanding imem fetch, redirect/kill.
// Optional IFU_MISALIGN_CHK_EN traps misaligned redirect targets locally.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             imem_resp_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_inst,
  output logic             out_fault,
`ifdef IFU_MISALIGN_CHK_EN
  output logic             out_misalign,
`endif
  output logic [1:0]       dbg_state
);

  // Handshakes: a request transfers on a cycle with imem_req_valid && imem_req_ready;
  // the output transfers on out_valid && out_ready; payloads hold while valid && !ready.

  ifu_state_e       state, state_n;
  logic             kill, kill_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic [WIDTH-1:0] redir_tgt;
  logic             misaligned;
  logic             req_fire;
  logic             outstanding;
  logic             buf_load;
  logic [WIDTH-1:0] ld_pc;
  logic [31:0]      ld_inst;
  logic             ld_fault;

`ifdef IFU_MISALIGN_CHK_EN
  logic ld_mis;
  assign redir_tgt  = redirect_pc;
  assign misaligned = is_misaligned(redirect_pc[1:0]);
  assign ld_mis     = redirect_valid && misaligned;
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^redirect_pc[1:0];
  assign redir_tgt  = {redirect_pc[WIDTH-1:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  // A lingering kill outside S_WAIT means a stale response is still owed;
  // holding the request back keeps at most one fetch outstanding.
  assign imem_req_valid = (state == S_REQ) && !kill;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign outstanding    = req_fire || (!imem_resp_valid && ((state == S_WAIT) || kill));
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      kill  <= 1'b0;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      kill  <= kill_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n  = state;
    kill_n   = kill;
    pc_n     = pc;
    buf_load = 1'b0;
    ld_pc    = pc;
    ld_inst  = imem_resp_data;
    ld_fault = imem_resp_err;

    case (state)
      S_REQ: begin
        if (req_fire) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            buf_load = 1'b1;
            state_n  = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          pc_n    = pc + WIDTH'(4);
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase

    if ((state != S_WAIT) && kill && imem_resp_valid) kill_n = 1'b0;

    // Redirect overrides every other PC update and any pending buffer load.
    if (redirect_valid) begin
      pc_n     = redir_tgt;
      buf_load = 1'b0;
      kill_n   = outstanding;
      if (misaligned) begin
        state_n  = S_OUT;
        buf_load = 1'b1;
        ld_pc    = redirect_pc;
        ld_inst  = '0;
        ld_fault = 1'b1;
      end else if (req_fire || ((state == S_WAIT) && !imem_resp_valid)) begin
        state_n = S_WAIT;
      end else begin
        state_n = S_REQ;
      end
    end
  end

  ifu_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_pc    (ld_pc),
    .load_inst  (ld_inst),
    .load_fault (ld_fault),
`ifdef IFU_MISALIGN_CHK_EN
    .load_misalign (ld_mis),
`endif
    .flush      (redirect_valid),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_fault  (out_fault)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .out_misalign (out_misalign)
`endif
  );

endmodule
